// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, formats load data, drives the regfile write port.
// Latency: non-load writes the edge after accept; a load writes the edge after its response.
// Backpressure: in_ready drops only while a load waits for mem_rvalid. Optional DIFFTEST_COMMIT_EN adds commit outputs.
module wb_stage #(
    parameter int XLEN      = 64,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_pc,
    input  logic [31:0]          in_inst,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_wen,
    input  logic [XLEN-1:0]      in_alu_res,
    input  logic                 in_is_load,
    input  logic [1:0]           in_ld_size,
    input  logic                 in_ld_unsigned,
    input  logic [2:0]           in_ld_off,
    input  logic                 mem_rvalid,
    input  logic [63:0]          mem_rdata,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 fwd_busy,
    output logic [4:0]           fwd_rd,
    output logic                 fwd_data_valid,
    output logic [XLEN-1:0]      fwd_data,
`ifdef DIFFTEST_COMMIT_EN
    output logic                 commit_valid,
    output logic [63:0]          commit_pc,
    output logic [31:0]          commit_inst,
    output logic                 commit_wen,
    output logic [4:0]           commit_wdest,
    output logic [63:0]          commit_wdata,
`endif
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESULT  = 2'd1,
        WAIT_LD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    pc_q;
    logic [31:0]    inst_q;
    logic [4:0]     rd_q;
    logic           rd_wen_q;
    logic [63:0]    data_q;
    logic [1:0]     ld_size_q;
    logic           ld_uns_q;
    logic [2:0]     ld_off_q;
    logic [INSTRET_W-1:0] instret_q;

    logic           accept;
    logic           ld_capture;
    logic [63:0]    ld_fmt;
    logic [7:0]     lane_b;
    logic [15:0]    lane_h;
    logic [31:0]    lane_w;
    logic           rd_live;

    assign in_ready   = (state_q == IDLE) || (state_q == RESULT);
    assign accept     = in_valid && in_ready;
    assign ld_capture = (state_q == WAIT_LD) && mem_rvalid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESULT: begin
                state_d = IDLE;
                if (accept) state_d = in_is_load ? WAIT_LD : RESULT;
            end
            WAIT_LD: if (mem_rvalid) state_d = RESULT;
            default: state_d = IDLE;
        endcase
    end

    // Lane selection uses the attributes latched at accept, not the live inputs.
    always_comb begin
        lane_b = mem_rdata[{ld_off_q, 3'b000} +: 8];
        lane_h = mem_rdata[{ld_off_q[2:1], 4'b0000} +: 16];
        lane_w = mem_rdata[{ld_off_q[2], 5'b00000} +: 32];
        ld_fmt = mem_rdata;
        case (ld_size_q)
            2'd0:    ld_fmt = {{56{lane_b[7] & ~ld_uns_q}}, lane_b};
            2'd1:    ld_fmt = {{48{lane_h[15] & ~ld_uns_q}}, lane_h};
            2'd2:    ld_fmt = {{32{lane_w[31] & ~ld_uns_q}}, lane_w};
            default: ld_fmt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            data_q    <= '0;
            ld_size_q <= '0;
            ld_uns_q  <= 1'b0;
            ld_off_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RESULT)
                instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
            if (accept) begin
                pc_q      <= in_pc;
                inst_q    <= in_inst;
                rd_q      <= in_rd;
                rd_wen_q  <= in_rd_wen;
                data_q    <= in_is_load ? 64'd0 : in_alu_res;
                ld_size_q <= in_ld_size;
                ld_uns_q  <= in_ld_unsigned;
                ld_off_q  <= in_ld_off;
            end else if (ld_capture) begin
                data_q <= ld_fmt;
            end
        end
    end

    assign rd_live        = rd_wen_q && (rd_q != 5'd0);
    assign rf_we          = (state_q == RESULT) && rd_live;
    assign rf_waddr       = rf_we ? rd_q : 5'd0;
    assign rf_wdata       = rf_we ? data_q : '0;
    assign fwd_busy       = (state_q != IDLE) && rd_live;
    assign fwd_rd         = rd_q;
    assign fwd_data_valid = (state_q == RESULT) && fwd_busy;
    assign fwd_data       = fwd_data_valid ? data_q : '0;
    assign instret        = instret_q;

`ifdef DIFFTEST_COMMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_inst  <= '0;
            commit_wen   <= 1'b0;
            commit_wdest <= '0;
            commit_wdata <= '0;
        end else begin
            commit_valid <= (state_q == RESULT);
            commit_pc    <= pc_q;
            commit_inst  <= inst_q;
            commit_wen   <= rf_we;
            commit_wdest <= rd_q;
            commit_wdata <= data_q;
        end
    end
`else
    logic unused_commit_fields;
    assign unused_commit_fields = ^{pc_q, inst_q};
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the in-order core; sits directly upstream of the register file and drives its single write port (we/waddr/wdata).
- Accepts retiring instructions from the memory stage over a valid/ready handshake.
- Waits for data-memory load responses, then aligns and sign/zero-extends load data.
- Retires one instruction per cycle; publishes forwarding/hazard information and an instret count.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset
- in_valid  input  1  memory stage presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_pc  input  64  instruction PC
- in_inst  input  32  instruction word
- in_rd  input  5  destination register
- in_rd_wen  input  1  instruction writes rd
- in_alu_res  input  64  non-load result
- in_is_load  input  1  result comes from the dmem response
- in_ld_size  input  2  0=byte, 1=half, 2=word, 3=double
- in_ld_unsigned  input  1  zero-extend when 1
- in_ld_off  input  3  load address bits [2:0]
- mem_rvalid  input  1  dmem load response valid
- mem_rdata  input  64  raw aligned 64-bit bus word
- rf_we  output  1  regfile write enable
- rf_waddr  output  5  regfile write address
- rf_wdata  output  64  regfile write data
- fwd_busy  output  1  stage holds a pending write to fwd_rd
- fwd_rd  output  5  pending destination
- fwd_data_valid  output  1  fwd_data is final
- fwd_data  output  64  pending result
- instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - state=IDLE; all holding registers 0; instret=0.
  - in_ready=1; rf_we=0, rf_waddr=0, rf_wdata=0; fwd_busy=0, fwd_rd=0, fwd_data_valid=0, fwd_data=0.
- Holding register: one entry (pc, inst, rd, rd_wen, data, load attributes).
- FSM states: IDLE (empty), RESULT (data final, retires this cycle), WAIT_LD (load awaiting response).
- in_ready = (state==IDLE) | (state==RESULT). A new instruction may be accepted in the same cycle the RESULT entry retires, giving one retire per cycle back-to-back.
- Accept = in_valid & in_ready. On accept:
  - in_is_load=0: capture in_alu_res; next state RESULT.
  - in_is_load=1: next state WAIT_LD.
- RESULT with no accept -> IDLE.
- WAIT_LD:
  - in_ready=0.
  - On mem_rvalid: capture formatted load data; next state RESULT.
  - mem_rvalid in IDLE or RESULT is ignored.
  - A response is never consumed in the cycle the load is accepted; earliest capture is the following edge.
- Latency: non-load accepted at edge N is written at edge N+1. Load response sampled at edge M is written at edge M+1.
- Register file write:
  - rf_we = (state==RESULT) & rd_wen & (rd!=0).
  - rf_waddr and rf_wdata come straight from the holding register.
  - rf_waddr and rf_wdata are 0 whenever rf_we=0.
- Retire: instret increments by 1 each cycle state==RESULT, including rd=x0 and non-writing instructions. It wraps modulo 2^INSTRET_W.
- Load formatting:
  - byte: mem_rdata[8*off +: 8].
  - half: lane off[2:1]; off[0] is ignored.
  - word: lane off[2]; off[1:0] are ignored.
  - double: whole word; off is ignored.
  - Sign-extend from the lane MSB unless in_ld_unsigned=1. in_ld_unsigned is ignored for double.
- Forwarding:
  - fwd_busy = (state!=IDLE) & rd_wen & (rd!=0).
  - fwd_rd = holding rd.
  - fwd_data_valid = (state==RESULT) & fwd_busy.
  - fwd_data = holding data when fwd_data_valid=1, else 0.
- Reset mid-operation: any state returns to IDLE and the pending entry is dropped with no write. A late mem_rvalid after reset is ignored.

Optional Feature:
- Macro: DIFFTEST_COMMIT_EN.
- Defined:
  - Adds outputs commit_valid (1), commit_pc (64), commit_inst (32), commit_wen (1), commit_wdest (5), commit_wdata (64).
  - Outputs are registered one cycle after retire: commit_valid=1 at edge N+1 for an instruction in RESULT during cycle N.
  - commit_wen equals that retire's rf_we. All commit outputs reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- ALU write: in_valid=1, rd=5, rd_wen=1, alu_res=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; instret=1 after that edge.
- Signed byte load:
  - Stimulus: is_load=1, size=0, unsigned=0, off=3; mem_rvalid two cycles later with rdata=0x00000000_80000000.
  - Response: rf_wdata=0xFFFFFFFF_FFFFFF80 one cycle after the response; in_ready=0 throughout WAIT_LD.
- Unsigned half load: size=1, unsigned=1, off=6, rdata=0xBEEF0000_00000000 -> rf_wdata=0x00000000_0000BEEF.
- Back-to-back and x0:
  - Stimulus: 4 consecutive ALU instructions with in_valid held high, the third with rd=0.
  - Response: in_ready stays 1; rf_we pattern 1,1,0,1; instret=4.
- Forwarding: load to rd=7 waiting -> fwd_busy=1, fwd_rd=7, fwd_data_valid=0; after response, fwd_data_valid=1 and fwd_data equals the formatted data.
- Reset during WAIT_LD:
  - Stimulus: assert rst_n=0 asynchronously, release it, then drive mem_rvalid=1.
  - Response: no rf_we, state IDLE, instret=0, in_ready=1.
